// File: rtl/mcc_pc_alu_ctrl.sv
// Multi-cycle CPU core: program counter, ALU with operand muxes,
// ALU output register and the multi-cycle control FSM.
module mcc_pc_alu_ctrl #(
    parameter int ADDRESS_BUS_WIDTH = 11,
    parameter int DATA_BUS_WIDTH    = 24,
    parameter int IMMEDIATE_WIDTH   = 11,
    parameter int WIDTH_OPCODE      = 4,
    parameter int RESET_ADDR        = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH_OPCODE-1:0]      opcode,
    input  logic [DATA_BUS_WIDTH-1:0]    rs1_data,
    input  logic [DATA_BUS_WIDTH-1:0]    rs2_data,
    input  logic [IMMEDIATE_WIDTH-1:0]   immediate,
    input  logic [ADDRESS_BUS_WIDTH-1:0] jump_address,
    output logic [ADDRESS_BUS_WIDTH-1:0] pc_addr,
    output logic [DATA_BUS_WIDTH-1:0]    alu_out,
    output logic [DATA_BUS_WIDTH-1:0]    alu_reg_out,
    output logic                         zero,
    output logic                         ir_write,
    output logic                         mem_to_reg,
    output logic                         mem_read_not_write,
    output logic                         mem_select,
    output logic                         reg_write,
    output logic                         halted
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;
    localparam int IW = IMMEDIATE_WIDTH;
    localparam int OW = WIDTH_OPCODE;

    localparam logic [OW-1:0] OP_ADD  = OW'(0);
    localparam logic [OW-1:0] OP_SUB  = OW'(1);
    localparam logic [OW-1:0] OP_AND  = OW'(2);
    localparam logic [OW-1:0] OP_OR   = OW'(3);
    localparam logic [OW-1:0] OP_XOR  = OW'(4);
    localparam logic [OW-1:0] OP_SLT  = OW'(5);
    localparam logic [OW-1:0] OP_ADDI = OW'(6);
    localparam logic [OW-1:0] OP_LW   = OW'(7);
    localparam logic [OW-1:0] OP_SW   = OW'(8);
    localparam logic [OW-1:0] OP_BEQ  = OW'(9);
    localparam logic [OW-1:0] OP_BNE  = OW'(10);
    localparam logic [OW-1:0] OP_JMP  = OW'(11);
    localparam logic [OW-1:0] OP_HALT = OW'(15);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_PASS = 3'd6;
    localparam logic [2:0] ALU_SLL  = 3'd7;

    localparam logic [1:0] B_RS2   = 2'd0;
    localparam logic [1:0] B_ONE   = 2'd1;
    localparam logic [1:0] B_IMM   = 2'd2;
    localparam logic [1:0] B_K1023 = 2'd3;

    localparam logic [1:0] PC_ALU   = 2'd0;
    localparam logic [1:0] PC_AREG  = 2'd1;
    localparam logic [1:0] PC_JUMP  = 2'd2;
    localparam logic [1:0] PC_RESET = 2'd3;

    localparam logic [AW-1:0] RESET_PC = AW'(RESET_ADDR);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   pc_d;
    logic [DW-1:0]   alu_reg_q;
    logic [DW-1:0]   alu_reg_d;

    logic            pc_write;
    logic [1:0]      pc_src;
    logic            a_sel;
    logic [1:0]      b_sel;
    logic [2:0]      alu_op;

    logic [DW-1:0]   imm_ext;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [DW-1:0]   alu_res;

    assign imm_ext = {{(DW-IW){immediate[IW-1]}}, immediate};

    // ALU operand selection
    always_comb begin
        op_a = a_sel ? rs1_data : {{(DW-AW){1'b0}}, pc_q};
        op_b = rs2_data;
        case (b_sel)
            B_RS2:   op_b = rs2_data;
            B_ONE:   op_b = DW'(1);
            B_IMM:   op_b = imm_ext;
            B_K1023: op_b = DW'(1023);
            default: op_b = rs2_data;
        endcase
    end

    // ALU function; arithmetic wraps at the data width
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = {{(DW-1){1'b0}},
                                 $signed(op_a) < $signed(op_b)};
            ALU_PASS: alu_res = op_b;
            ALU_SLL:  alu_res = op_a << op_b[4:0];
            default:  alu_res = '0;
        endcase
    end

    assign alu_out = alu_res;
    assign zero    = (alu_res == '0);

    // Next PC from the PC source mux, gated by pc_write
    always_comb begin
        pc_d = pc_q;
        if (pc_write) begin
            case (pc_src)
                PC_ALU:   pc_d = alu_res[AW-1:0];
                PC_AREG:  pc_d = alu_reg_q[AW-1:0];
                PC_JUMP:  pc_d = jump_address;
                PC_RESET: pc_d = RESET_PC;
                default:  pc_d = pc_q;
            endcase
        end
    end

    // ALU output register captures every cycle
    always_comb begin
        alu_reg_d = alu_res;
    end

    // Control FSM: next state and per-state datapath strobes
    always_comb begin
        state_d            = state_q;
        ir_write           = 1'b0;
        pc_write           = 1'b0;
        pc_src             = PC_ALU;
        a_sel              = 1'b0;
        b_sel              = B_RS2;
        alu_op             = ALU_ADD;
        reg_write          = 1'b0;
        mem_to_reg         = 1'b0;
        mem_select         = 1'b0;
        mem_read_not_write = 1'b1;
        halted             = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                b_sel    = B_ONE;
                pc_src   = PC_ALU;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                b_sel = B_IMM;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND,
                    OP_OR, OP_XOR, OP_SLT: state_d = S_EXEC_R;
                    OP_ADDI:               state_d = S_EXEC_I;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:        state_d = S_BRANCH;
                    OP_JMP:                state_d = S_JUMP;
                    OP_HALT:               state_d = S_HALT;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                a_sel   = 1'b1;
                b_sel   = B_RS2;
                alu_op  = opcode[2:0];
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                a_sel   = 1'b1;
                b_sel   = B_IMM;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                a_sel   = 1'b1;
                b_sel   = B_IMM;
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_select = 1'b1;
                state_d    = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_select         = 1'b1;
                mem_read_not_write = 1'b0;
                state_d            = S_FETCH;
            end
            S_BRANCH: begin
                a_sel    = 1'b1;
                b_sel    = B_RS2;
                alu_op   = ALU_SUB;
                pc_src   = PC_AREG;
                pc_write = (opcode == OP_BNE) ? ~zero : zero;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC and ALU output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            alu_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            alu_reg_q <= alu_reg_d;
        end
    end

    assign pc_addr     = pc_q;
    assign alu_reg_out = alu_reg_q;

endmodule

// File: tb/tb_mcc_pc_alu_ctrl.sv
// Bench for mcc_pc_alu_ctrl: instruction-level reference model
// driving per-cycle expectations, plus directed literal checks.
module tb_mcc_pc_alu_ctrl;

    logic        clock;
    logic        reset;
    logic [3:0]  opcode;
    logic [23:0] rs1_data;
    logic [23:0] rs2_data;
    logic [10:0] immediate;
    logic [10:0] jump_address;
    logic [10:0] pc_addr;
    logic [23:0] alu_out;
    logic [23:0] alu_reg_out;
    logic        zero;
    logic        ir_write;
    logic        mem_to_reg;
    logic        mem_read_not_write;
    logic        mem_select;
    logic        reg_write;
    logic        halted;

    mcc_pc_alu_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .opcode             (opcode),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .immediate          (immediate),
        .jump_address       (jump_address),
        .pc_addr            (pc_addr),
        .alu_out            (alu_out),
        .alu_reg_out        (alu_reg_out),
        .zero               (zero),
        .ir_write           (ir_write),
        .mem_to_reg         (mem_to_reg),
        .mem_read_not_write (mem_read_not_write),
        .mem_select         (mem_select),
        .reg_write          (reg_write),
        .halted             (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // per-cycle expectations
    bit          chk_en = 0;
    bit          e_ir, e_rw, e_m2r, e_msel, e_mrnw, e_halt;
    logic [10:0] e_pc;
    bit          e_av;
    logic [23:0] e_alu;
    bit          e_arov;
    logic [23:0] e_aro;
    bit          last_av = 1;
    logic [23:0] last_alu = '0;

    // model state
    logic [10:0] mpc = '0;
    logic [23:0] cap_alu, cap_aro, cap_exec, cap_mem;
    logic        cap_zero, cap_exec_zero;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] sx(input logic [10:0] i);
        return {{13{i[10]}}, i};
    endfunction

    function automatic logic [23:0] ref_alu(input int op,
                                            input logic [23:0] a,
                                            input logic [23:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
            default: return 24'd0;
        endcase
    endfunction

    // compare process
    always @(negedge clock) begin
        if (chk_en) begin
            check("ir_write", ir_write, e_ir);
            check("reg_write", reg_write, e_rw);
            check("mem_to_reg", mem_to_reg, e_m2r);
            check("mem_select", mem_select, e_msel);
            check("mem_read_not_write", mem_read_not_write, e_mrnw);
            check("halted", halted, e_halt);
            check("pc_addr", pc_addr, e_pc);
            if (e_av) begin
                check("alu_out", alu_out, e_alu);
                check("zero", zero, e_alu == 24'd0);
            end
            if (e_arov) check("alu_reg_out", alu_reg_out, e_aro);
        end
    end

    // one clock cycle of expected behaviour; entered at posedge+1
    task automatic cyc(input bit ir, input bit rw, input bit m2r,
                       input bit msel, input bit mrnw, input bit hlt,
                       input logic [10:0] pc, input bit av,
                       input logic [23:0] a);
        e_ir = ir; e_rw = rw; e_m2r = m2r; e_msel = msel;
        e_mrnw = mrnw; e_halt = hlt; e_pc = pc;
        e_av = av; e_alu = a;
        e_arov = last_av; e_aro = last_alu;
        chk_en = 1;
        @(negedge clock);
        cap_alu = alu_out; cap_aro = alu_reg_out; cap_zero = zero;
        @(posedge clock);
        #1;
        last_av = av; last_alu = a;
    endtask

    // one full instruction from FETCH back to the next FETCH
    task automatic run_instr(input int op, input logic [23:0] r1,
                             input logic [23:0] r2,
                             input logic [10:0] imm,
                             input logic [10:0] ja);
        logic [10:0] pc0, pc1;
        logic [23:0] tgt, d;
        bit taken;
        pc0 = mpc;
        pc1 = pc0 + 11'd1;
        opcode = 4'(op); rs1_data = r1; rs2_data = r2;
        immediate = imm; jump_address = ja;
        cyc(1, 0, 0, 0, 1, 0, pc0, 1, {13'd0, pc0} + 24'd1);
        tgt = {13'd0, pc1} + sx(imm);
        cyc(0, 0, 0, 0, 1, 0, pc1, 1, tgt);
        mpc = pc1;
        if (op <= 5) begin
            cyc(0, 0, 0, 0, 1, 0, pc1, 1, ref_alu(op, r1, r2));
            cap_exec = cap_alu; cap_exec_zero = cap_zero;
            cyc(0, 1, 0, 0, 1, 0, pc1, 0, '0);
        end else if (op == 6) begin
            cyc(0, 0, 0, 0, 1, 0, pc1, 1, r1 + sx(imm));
            cap_exec = cap_alu;
            cyc(0, 1, 0, 0, 1, 0, pc1, 0, '0);
        end else if (op == 7) begin
            cyc(0, 0, 0, 0, 1, 0, pc1, 1, r1 + sx(imm));
            cyc(0, 0, 0, 1, 1, 0, pc1, 0, '0);
            cap_mem = cap_aro;
            cyc(0, 1, 1, 0, 1, 0, pc1, 0, '0);
        end else if (op == 8) begin
            cyc(0, 0, 0, 0, 1, 0, pc1, 1, r1 + sx(imm));
            cyc(0, 0, 0, 1, 0, 0, pc1, 0, '0);
            cap_mem = cap_aro;
        end else if (op == 9 || op == 10) begin
            d = r1 - r2;
            cyc(0, 0, 0, 0, 1, 0, pc1, 1, d);
            taken = (op == 9) ? (d == 0) : (d != 0);
            if (taken) mpc = tgt[10:0];
        end else if (op == 11) begin
            cyc(0, 0, 0, 0, 1, 0, pc1, 0, '0);
            mpc = ja;
        end
    endtask

    initial begin
        logic [23:0] r1, r2;
        logic [10:0] pc0, pc1;
        int op;
        reset = 1'b0;
        opcode = 4'd12; rs1_data = '0; rs2_data = '0;
        immediate = '0; jump_address = '0;

        // reset held: strobes decode from FETCH, no update
        repeat (3) @(posedge clock);
        #1;
        check("rst_ir_write", ir_write, 1);
        check("rst_pc", pc_addr, 0);
        check("rst_alu_reg", alu_reg_out, 0);
        check("rst_reg_write", reg_write, 0);
        reset = 1'b1;
        mpc = '0; last_av = 1; last_alu = '0;

        // directed
        run_instr(0, 24'd5, 24'd7, 11'd0, 11'd0);
        check("add_5_7", cap_exec, 24'd12);
        check("add_pc_plus1", pc_addr, 11'd1);
        run_instr(1, 24'd3, 24'd5, 11'd0, 11'd0);
        check("sub_3_5", cap_exec, 24'hFFFFFE);
        check("sub_3_5_zero", cap_exec_zero, 0);
        run_instr(5, 24'hFFFFFF, 24'd1, 11'd0, 11'd0);
        check("slt_neg", cap_exec, 24'd1);
        run_instr(1, 24'd9, 24'd9, 11'd0, 11'd0);
        check("sub_eq_zero", cap_exec_zero, 1);
        run_instr(11, '0, '0, '0, 11'd10);
        run_instr(7, 24'd100, '0, 11'h7FC, '0);
        check("lw_addr", cap_mem, 24'd96);
        run_instr(11, '0, '0, '0, 11'd10);
        run_instr(8, 24'd100, '0, 11'h7FC, '0);
        check("sw_addr", cap_mem, 24'd96);
        run_instr(11, '0, '0, '0, 11'd20);
        run_instr(9, 24'd44, 24'd44, 11'd5, '0);
        check("beq_taken", pc_addr, 11'd26);
        run_instr(11, '0, '0, '0, 11'd20);
        run_instr(9, 24'd44, 24'd45, 11'd5, '0);
        check("beq_not_taken", pc_addr, 11'd21);
        run_instr(11, '0, '0, '0, 11'd20);
        run_instr(10, 24'd44, 24'd44, 11'd5, '0);
        check("bne_not_taken", pc_addr, 11'd21);
        run_instr(11, '0, '0, '0, 11'd20);
        run_instr(10, 24'd44, 24'd45, 11'd5, '0);
        check("bne_taken", pc_addr, 11'd26);
        run_instr(11, '0, '0, '0, 11'd300);
        check("jmp_300", pc_addr, 11'd300);
        run_instr(11, '0, '0, '0, 11'd2047);
        run_instr(13, '0, '0, '0, '0);
        check("pc_wrap", pc_addr, 11'd0);

        // randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 14);
            r1 = 24'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 24'($urandom);
            run_instr(op, r1, r2, 11'($urandom), 11'($urandom));
        end

        // reset pulse during MEM_WB of a load
        pc0 = mpc; pc1 = pc0 + 11'd1;
        opcode = 4'd7; rs1_data = 24'd500; immediate = 11'd3;
        cyc(1, 0, 0, 0, 1, 0, pc0, 1, {13'd0, pc0} + 24'd1);
        cyc(0, 0, 0, 0, 1, 0, pc1, 1, {13'd0, pc1} + 24'd3);
        cyc(0, 0, 0, 0, 1, 0, pc1, 1, 24'd503);
        cyc(0, 0, 0, 1, 1, 0, pc1, 0, '0);
        check("memwb_reg_write", reg_write, 1);
        chk_en = 0;
        #2 reset = 1'b0;
        #1;
        check("abort_reg_write", reg_write, 0);
        check("abort_mem_to_reg", mem_to_reg, 0);
        check("abort_pc", pc_addr, 0);
        check("abort_ir_write", ir_write, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        mpc = '0; last_av = 1; last_alu = '0;

        // a few more instructions, then HALT
        run_instr(6, 24'd40, '0, 11'h7FF, '0);
        check("addi_neg1", cap_exec, 24'd39);
        pc0 = mpc; pc1 = pc0 + 11'd1;
        opcode = 4'd15;
        cyc(1, 0, 0, 0, 1, 0, pc0, 1, {13'd0, pc0} + 24'd1);
        cyc(0, 0, 0, 0, 1, 0, pc1, 1, {13'd0, pc1} + sx(immediate));
        repeat (10) cyc(0, 0, 0, 0, 1, 1, pc1, 0, '0);
        check("halt_pc_frozen", pc_addr, 11'd2);
        check("halt_flag", halted, 1);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mcc_pc_alu_ctrl.md
Name: mcc_pc_alu_ctrl

Overview:
- Core of the multi-cycle CPU: program counter register, PC source mux, ALU with operand muxes, ALU output register and the multi-cycle control FSM.
- Instruction RAM, register file, data RAM, instruction register and decoder are external.
- The block consumes the decoded opcode and operand data, and drives the PC address, ALU results and every datapath control strobe.

Parameters:
- ADDRESS_BUS_WIDTH, 11, PC and memory address width.
- DATA_BUS_WIDTH, 24, ALU and data width.
- IMMEDIATE_WIDTH, 11, immediate field width; sign-extended to DATA_BUS_WIDTH.
- WIDTH_OPCODE, 4, opcode width.
- RESET_ADDR, 0, PC value loaded on reset; also mux input 3.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  WIDTH_OPCODE  opcode from the decoder (reads the IR).
- rs1_data  in  DATA_BUS_WIDTH  register-file read port 1.
- rs2_data  in  DATA_BUS_WIDTH  register-file read port 2.
- immediate  in  IMMEDIATE_WIDTH  signed immediate.
- jump_address  in  ADDRESS_BUS_WIDTH  absolute jump target.
- pc_addr  out  ADDRESS_BUS_WIDTH  current PC.
- alu_out  out  DATA_BUS_WIDTH  combinational ALU result.
- alu_reg_out  out  DATA_BUS_WIDTH  ALU output register; the data RAM address source.
- zero  out  1  high when alu_out == 0.
- ir_write  out  1  instruction-register load enable.
- mem_to_reg  out  1  1 = write-back from memory register, 0 = from alu_reg_out.
- mem_read_not_write  out  1  data RAM direction.
- mem_select  out  1  data RAM chip select.
- reg_write  out  1  register-file write enable.
- halted  out  1  FSM in HALT.

Behaviour:
- Reset (reset=0, async): pc_addr=RESET_ADDR, alu_reg_out=0, state=FETCH. In FETCH the datapath strobes are decoded from state, so ir_write and pc write are active while reset is held, but no register updates.
- ALU A mux: sel 0 = {zeros, pc_addr}; sel 1 = rs1_data.
- ALU B mux: sel 0 = rs2_data; 1 = 1; 2 = sign-extended immediate; 3 = 1023.
- ALUop codes (3 bits): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed; result 1/0), 6 PASS_B, 7 SLL by B[4:0]. Arithmetic wraps modulo 2^DATA_BUS_WIDTH. zero is combinational on alu_out.
- alu_reg_out <= alu_out every clock.
- PC mux: 0 = alu_out[ADDRESS_BUS_WIDTH-1:0]; 1 = alu_reg_out[ADDRESS_BUS_WIDTH-1:0]; 2 = jump_address; 3 = RESET_ADDR. The PC loads only when the internal pc_write is 1.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 JMP, 15 HALT; 12-14 are NOP (DECODE then FETCH).
- FSM per state (unlisted strobes 0; mem_read_not_write defaults 1):
  - FETCH: ir_write=1, A=PC, B=1, ADD, PCsrc=0, pc_write=1 -> DECODE.
  - DECODE: A=PC, B=imm, ADD (branch target into alu_reg_out). Next state by opcode: R-type->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, JMP->JUMP, HALT->HALT.
  - EXEC_R: A=rs1, B=rs2, ALUop per opcode -> ALU_WB.
  - EXEC_I: A=rs1, B=imm, ADD -> ALU_WB.
  - ALU_WB: reg_write=1, mem_to_reg=0 -> FETCH.
  - MEM_ADDR: A=rs1, B=imm, ADD -> MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ: mem_select=1, mem_read_not_write=1 -> MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH.
  - MEM_WRITE: mem_select=1, mem_read_not_write=0 -> FETCH.
  - BRANCH: A=rs1, B=rs2, SUB, PCsrc=1. pc_write=zero for BEQ, ~zero for BNE -> FETCH.
  - JUMP: PCsrc=2, pc_write=1 -> FETCH.
  - HALT: all enables 0, halted=1; stays in HALT until reset.
- Latency in cycles: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE/JMP 3.
- PC wraps at 2^ADDRESS_BUS_WIDTH (2047+1 -> 0).
- Reset asserted mid-instruction aborts it immediately; no partial write-back strobe after reset.

Test Plan:
- Reset low then high -> pc_addr=0, FETCH; first edge ir_write=1, pc_addr=1, next state DECODE.
- ADD, rs1=5, rs2=7 -> EXEC_R alu_out=12; ALU_WB reg_write=1, mem_to_reg=0; PC advanced by exactly 1 over 4 cycles.
- SUB, rs1=3, rs2=5 -> alu_out=0xFFFFFE, zero=0. SLT 0xFFFFFF vs 1 -> 1. rs1=rs2=9 SUB -> zero=1.
- LW at PC=10, rs1=100, imm=-4 -> alu_reg_out=96 in MEM_READ with mem_select=1, mem_read_not_write=1; MEM_WB mem_to_reg=1. SW same operands -> mem_read_not_write=0 at address 96.
- BEQ at PC=20, imm=5, rs1=rs2 -> pc_addr=26 after 3 cycles. Same with rs1≠rs2 -> 21. BNE gives the inverse.
- JMP, jump_address=300 -> pc_addr=300. HALT -> halted=1, pc frozen for 10 cycles. PC=2047 fetch -> 0. Reset pulse during MEM_WB -> reg_write drops immediately, pc_addr=0.
